// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor run controller.
//   CNT_W   : width of the RUN-cycle counter exposed as cycle_count
//   state_e : controller FSM states
package proc_ctrl_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_RUN     = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_WAIT = 3'd4,
    S_SEND    = 3'd5
  } state_e;

endpackage

// File: rtl/run_timer.sv
// RUN-phase cycle counter with timeout detection.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the count (new run)
//   enable   : count one RUN cycle
//   count    : cycles counted so far (saturates, never wraps)
//   expired  : count has reached TIMEOUT-1 (this cycle is the last allowed)
module run_timer
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller: resets a processor, lets it run until it reports completion
// (or a timeout), then reads DUMP_WORDS words of its data memory back out
// through a valid/ready port.
//   clk, rst            : clock, synchronous active-high reset
//   start               : run request (only honoured in IDLE)
//   proc_state          : processor completion level
//   proc_rst            : processor reset, held low after a run for read-back
//   mem_addr/mem_rdata  : data-memory read port, one-cycle read latency
//   dump_data/valid/ready : read-back word stream
//   busy, done, timeout : status; done/timeout sticky until next start
//   cycle_count         : RUN cycles counted
module proc_run_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DUMP_WORDS  = 16,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              proc_state,
  output logic              proc_rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [WIDTH-1:0]  dump_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DUMP_WORDS - 1);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                proc_rst_q, proc_rst_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                tmr_clear, tmr_en, tmr_expired;

  run_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .count   (cycle_count),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    addr_d     = addr_q;
    data_d     = data_q;
    proc_rst_d = proc_rst_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    tmr_clear  = 1'b0;
    tmr_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_HOLD;
          hold_d     = '0;
          proc_rst_d = 1'b1;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          tmr_clear  = 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d    = S_RUN;
          proc_rst_d = 1'b0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        // Completion wins over a timeout landing in the same cycle.
        if (proc_state) begin
          state_d = S_RD_ADDR;
          addr_d  = '0;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
            done_d    = 1'b1;
          end
        end
      end
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        data_d  = mem_rdata;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (dump_ready) begin
          if (addr_q == ADDR_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_RD_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      proc_rst_q <= 1'b1;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      proc_rst_q <= proc_rst_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign proc_rst   = proc_rst_q;
  assign mem_addr   = addr_q;
  assign dump_data  = data_q;
  assign dump_valid = (state_q == S_SEND);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign timeout    = timeout_q;

endmodule

// File: doc/proc_run_ctrl.md
PROC_RUN_CTRL -- requirements
Module: proc_run_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, processor data-memory word width.
REQ-002 SHALL have parameter ADDR_W, default 8, data-memory address width.
REQ-003 SHALL have parameter DUMP_WORDS, default 16, words read back after completion (1..2^ADDR_W).
REQ-004 SHALL have parameter HOLD_CYCLES, default 4, processor reset hold length (>=1).
REQ-005 SHALL have parameter TIMEOUT, default 1000, max RUN cycles (>=1); CNT_W=16.
REQ-006 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port start  in  1  run request, sampled only in IDLE.
REQ-009 SHALL have port proc_state  in  1  processor completion level.
REQ-010 SHALL have port proc_rst  out  1  processor reset, active-high.
REQ-011 SHALL have port mem_addr  out  ADDR_W  data-memory read address.
REQ-012 SHALL have port mem_rdata  in  WIDTH  read data, valid 1 cycle after mem_addr.
REQ-013 SHALL have port dump_data  out  WIDTH  read-back word.
REQ-014 SHALL have port dump_valid  out  1  dump_data valid.
REQ-015 SHALL have port dump_ready  in  1  sink accepts word.
REQ-016 SHALL have ports busy, done, timeout  out  1 each  status flags.
REQ-017 SHALL have port cycle_count  out  CNT_W  RUN cycles counted.

Function
REQ-018 SHALL implement states IDLE, HOLD, RUN, RD_ADDR, RD_WAIT, SEND.
REQ-019 IDLE: start=1 -> HOLD; clear done, timeout, cycle_count; assert proc_rst; start ignored in all other states.
REQ-020 HOLD: proc_rst=1 for exactly HOLD_CYCLES cycles, then RUN with proc_rst=0.
REQ-021 RUN: proc_state=1 -> RD_ADDR, address 0, count unchanged; proc_state has priority over timeout in the same cycle.
REQ-022 RUN: proc_state=0 and cycle_count==TIMEOUT-1 -> cycle_count=TIMEOUT, timeout=1, done=1, IDLE, no dump.
REQ-023 RUN: otherwise cycle_count increments by 1; never wraps.
REQ-024 RD_ADDR: drive mem_addr -> RD_WAIT; RD_WAIT: capture mem_rdata into dump_data -> SEND.
REQ-025 SEND: dump_valid=1, dump_data stable until dump_valid&dump_ready; on handshake dump_valid falls next cycle.
REQ-026 SEND handshake: if address==DUMP_WORDS-1 -> done=1, IDLE; else address+1, RD_ADDR.
REQ-027 proc_rst SHALL stay 0 after RUN until next accepted start (processor and memory retained for read-back).
REQ-028 busy=1 in every state except IDLE; done, timeout sticky until next accepted start.
REQ-029 Per-word latency: handshake to next dump_valid = 3 cycles with dump_ready held 1.
REQ-030 mem_addr SHALL hold last value outside read states; address arithmetic ADDR_W bits, no wrap past DUMP_WORDS-1.

Reset
REQ-031 rst=1 SHALL force IDLE, proc_rst=1, mem_addr=0, dump_data=0, dump_valid=0, busy=0, done=0, timeout=0, cycle_count=0.
REQ-032 rst mid-RUN or mid-SEND SHALL abort immediately; dropped word not re-sent; rst dominates start.

Structure
REQ-033 State encoding and CNT_W SHALL live in shared package proc_ctrl_pkg.
REQ-034 Counter/timeout logic MAY be sub-module run_timer (clear, enable, count, expired); FSM stays in proc_run_ctrl.

Verification
REQ-035 start pulse, proc_state rises 10 cycles after proc_rst falls -> proc_rst high 4 cycles, cycle_count=10, 16 words addr 0..15, done=1, timeout=0.
REQ-036 proc_state never rises, TIMEOUT=1000 -> timeout=1, done=1, cycle_count=1000, dump_valid never asserted, busy falls.
REQ-037 dump_ready toggled 0/1 randomly with memory word i=i*3 -> dump_data sequence 0,3,6,...,45, each stable while valid&!ready.
REQ-038 proc_state=1 on first RUN cycle -> cycle_count=0, dump proceeds.
REQ-039 rst at 3rd SEND word -> all outputs at reset values next cycle; new start reruns from address 0.
REQ-040 start pulses while busy -> ignored; done/timeout unchanged until run completes.
